// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage data-bus access unit: size codes, FSM states, dbus structs.
// Pure declarations; no timing behaviour of its own.
package mem_access_unit_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_D = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } mau_state_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   addr;
    msize_t            size;
    logic [XLEN/8-1:0] strobe;
    logic [XLEN-1:0]   data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;

  // Everything needed to replay an access from the latch while the bus is busy.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    mem_size_t       size;
    logic            is_unsigned;
    logic            is_load;
    logic            is_store;
  } mau_req_t;

  function automatic msize_t to_msize(input mem_size_t s);
    case (s)
      MEM_B:   return MSIZE1;
      MEM_H:   return MSIZE2;
      MEM_W:   return MSIZE4;
      default: return MSIZE8;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the dbus: store strobe/data shift, misalign detect, load shift and extend.
// Purely combinational, zero latency; no flow control of its own.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [XLEN-1:0]   addr_i,
  input  mem_size_t         size_i,
  input  logic              is_unsigned_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   bus_rdata_i,
  output logic [XLEN/8-1:0] strobe_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              misalign_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [2:0]      ofs;
  logic [5:0]      bit_ofs;
  logic [7:0]      base_strobe;
  logic [XLEN-1:0] lane;
  logic            sext;

  assign ofs     = addr_i[2:0];
  assign bit_ofs = {ofs, 3'b000};
  assign sext    = ~is_unsigned_i;

  always_comb begin
    base_strobe = 8'hFF;
    misalign_o  = 1'b0;
    unique case (size_i)
      MEM_B: begin base_strobe = 8'h01; misalign_o = 1'b0;            end
      MEM_H: begin base_strobe = 8'h03; misalign_o = ofs[0];          end
      MEM_W: begin base_strobe = 8'h0F; misalign_o = |ofs[1:0];       end
      MEM_D: begin base_strobe = 8'hFF; misalign_o = |ofs;            end
    endcase
  end

  assign strobe_o = base_strobe << ofs;
  assign wdata_o  = wdata_i << bit_ofs;
  assign lane     = bus_rdata_i >> bit_ofs;

  always_comb begin
    rdata_o = lane;
    unique case (size_i)
      MEM_B: rdata_o = {{56{sext & lane[7]}},  lane[7:0]};
      MEM_H: rdata_o = {{48{sext & lane[15]}}, lane[15:0]};
      MEM_W: rdata_o = {{32{sext & lane[31]}}, lane[31:0]};
      MEM_D: rdata_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage dbus access unit: one bus transaction per EX/MEM load/store, extended load data to MEM/WB.
// Zero-latency when data_ok arrives in the issue cycle; otherwise stall_m holds the pipe until data_ok.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_memread,
  input  logic            in_memwrite,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic            pipe_advance,
  output dbus_req_t       dreq,
  input  dbus_resp_t      dresp,
  output logic            stall_m,
  output logic [XLEN-1:0] rdata,
  output logic            done,
  output logic            misalign
);

  mau_state_t        state_q, state_d;
  mau_req_t          lat_q, lat_d;
  logic [XLEN-1:0]   buf_q, buf_d;

  mau_req_t          in_req, cur;
  logic [XLEN/8-1:0] strobe;
  logic [XLEN-1:0]   wdata_sh, ext, load_val;
  logic              align_mis, mem_op, access;
  logic              unused_addr_ok;

  assign unused_addr_ok = dresp.addr_ok;

  assign in_req = '{addr: in_addr, wdata: in_wdata, size: mem_size_t'(in_size),
                    is_unsigned: in_unsigned, is_load: in_memread, is_store: in_memwrite};

  // While BUSY the request must stay bit-stable, so steer from the latch rather than the inputs.
  assign cur = (state_q == BUSY) ? lat_q : in_req;

  mem_align u_align (
    .addr_i        (cur.addr),
    .size_i        (cur.size),
    .is_unsigned_i (cur.is_unsigned),
    .wdata_i       (cur.wdata),
    .bus_rdata_i   (dresp.data),
    .strobe_o      (strobe),
    .wdata_o       (wdata_sh),
    .misalign_o    (align_mis),
    .rdata_o       (ext)
  );

  assign mem_op   = in_valid & (in_memread | in_memwrite);
  assign access   = mem_op & ~align_mis;
  assign load_val = cur.is_load ? ext : '0;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    buf_d       = buf_q;
    dreq        = '0;
    stall_m     = 1'b0;
    done        = 1'b0;
    rdata       = '0;
    misalign    = 1'b0;
    dreq.addr   = cur.addr;
    dreq.size   = to_msize(cur.size);
    dreq.strobe = cur.is_store ? strobe : '0;
    dreq.data   = cur.is_store ? wdata_sh : '0;

    unique case (state_q)
      IDLE: begin
        misalign   = mem_op & align_mis;
        dreq.valid = access;
        done       = in_valid & ~access;
        if (access) begin
          stall_m = ~dresp.data_ok;
          if (dresp.data_ok) begin
            done  = 1'b1;
            rdata = load_val;
            if (!pipe_advance) begin
              state_d = HOLD;
              buf_d   = load_val;
            end
          end else begin
            state_d = BUSY;
            lat_d   = in_req;
          end
        end
      end
      BUSY: begin
        dreq.valid = 1'b1;
        stall_m    = ~dresp.data_ok;
        if (dresp.data_ok) begin
          done  = 1'b1;
          rdata = load_val;
          if (pipe_advance) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            buf_d   = load_val;
          end
        end
      end
      HOLD: begin
        // Data already returned; the instruction is still in EX/MEM, so no new request.
        done  = 1'b1;
        rdata = buf_q;
        if (pipe_advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      dreq     = '0;
      stall_m  = 1'b0;
      done     = 1'b0;
      rdata    = '0;
      misalign = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized load/store streams against a lane-arithmetic model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_memread, in_memwrite, in_unsigned, pipe_advance;
  logic [63:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        stall_m, done, misalign;
  logic [63:0] rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size),
    .in_unsigned(in_unsigned), .pipe_advance(pipe_advance), .dreq(dreq), .dresp(dresp),
    .stall_m(stall_m), .rdata(rdata), .done(done), .misalign(misalign)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_strobe(input logic [1:0] sz, input logic [63:0] a);
    logic [15:0] s;
    s = ((16'd1 << (1 << sz)) - 16'd1) << a[2:0];
    return s[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [63:0] a);
    return wd << (8 * a[2:0]);
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] bus, input logic [63:0] a,
                                         input logic [1:0] sz, input logic uns);
    int          nb;
    logic [63:0] lane, mask;
    nb   = 8 << sz;
    lane = bus >> (8 * a[2:0]);
    if (nb == 64) return lane;
    mask = (64'd1 << nb) - 64'd1;
    lane = lane & mask;
    if (!uns && lane[nb-1]) lane = lane | ~mask;
    return lane;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [63:0] a);
    return (a & ((64'd1 << sz) - 64'd1)) != 64'd0;
  endfunction

  function automatic msize_t m_msize(input logic [1:0] sz);
    case (sz)
      2'd0:    return MSIZE1;
      2'd1:    return MSIZE2;
      2'd2:    return MSIZE4;
      default: return MSIZE8;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic [63:0] a,
                        input logic [63:0] wd, input logic [1:0] sz, input logic u);
    in_valid = v; in_memread = rd; in_memwrite = wr; in_addr = a;
    in_wdata = wd; in_size = sz; in_unsigned = u;
  endtask

  task automatic set_resp(input logic ok, input logic [63:0] d, input logic adv);
    dresp.addr_ok = 1'b1; dresp.data_ok = ok; dresp.data = d; pipe_advance = adv;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_op(1, 1, 0, 64'h8000_1000, 64'h0, 2'd3, 0);
    set_resp(0, 64'hDEAD_BEEF_0000_0001, 1);
    #12;
    total++;
    if ({dreq.valid, stall_m, done, misalign} !== 4'b0000 || rdata !== 64'h0) begin
      bad++;
      $display("FAIL reset_outputs got v/s/d/m=%b rdata=%h want 0000 / 0",
               {dreq.valid, stall_m, done, misalign}, rdata);
    end
    set_op(1, 1, 0, 64'h8000_0002, 64'h0, 2'd2, 0);
    #2;
    total++;
    if (misalign !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_misalign got m=%b d=%b want 0 0", misalign, done);
    end
    set_op(0, 0, 0, 64'h0, 64'h0, 2'd0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ld_latency();
    logic [63:0] d;
    d = 64'h0123_4567_89AB_CDEF;
    set_op(1, 1, 0, 64'h8000_1000, 64'h0, 2'd3, 0);
    for (int c = 0; c < 4; c++) begin
      set_resp(c == 3, (c == 3) ? d : {$urandom, $urandom}, c == 3);
      @(negedge clk);
      total++;
      if (stall_m !== (c < 3)) begin
        bad++; $display("FAIL ld_stall c=%0d got=%b want=%b", c, stall_m, c < 3);
      end
      total++;
      if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_1000 || dreq.size !== MSIZE8) begin
        bad++; $display("FAIL ld_fields c=%0d got v=%b a=%h s=%0d want 1 80001000 MSIZE8",
                        c, dreq.valid, dreq.addr, dreq.size);
      end
      if (c == 3) begin
        total++;
        if (rdata !== d || done !== 1'b1) begin
          bad++; $display("FAIL ld_rdata got=%h done=%b want=%h 1", rdata, done, d);
        end
      end
      tick();
    end
  endtask

  task automatic test_lb_ext();
    logic [63:0] want [2];
    want[0] = 64'hFFFF_FFFF_FFFF_FF80;
    want[1] = 64'h0000_0000_0000_0080;
    for (int u = 0; u < 2; u++) begin
      set_op(1, 1, 0, 64'h8000_0003, 64'h0, 2'd0, u[0]);
      set_resp(1, 64'h0000_0000_8000_0000, 1);
      @(negedge clk);
      total++;
      if (rdata !== want[u] || stall_m !== 1'b0 || done !== 1'b1) begin
        bad++; $display("FAIL lb_ext uns=%0d got=%h s=%b d=%b want=%h 0 1",
                        u, rdata, stall_m, done, want[u]);
      end
      tick();
    end
  endtask

  task automatic test_sh();
    set_op(1, 0, 1, 64'h8000_0006, 64'h1234, 2'd1, 0);
    set_resp(1, {$urandom, $urandom}, 1);
    @(negedge clk);
    total++;
    if (dreq.strobe !== 8'hC0 || dreq.data !== 64'h1234_0000_0000_0000 || dreq.size !== MSIZE2
        || dreq.valid !== 1'b1) begin
      bad++; $display("FAIL sh_fields got v=%b st=%h d=%h s=%0d want 1 c0 1234000000000000 MSIZE2",
                      dreq.valid, dreq.strobe, dreq.data, dreq.size);
    end
    total++;
    if (rdata !== 64'h0) begin
      bad++; $display("FAIL sh_rdata got=%h want 0", rdata);
    end
    tick();
  endtask

  task automatic test_hold();
    logic [63:0] d, want;
    d    = 64'h8765_4321_F000_0001;
    want = m_load(d, 64'h8000_0004, 2'd2, 0);
    set_op(1, 1, 0, 64'h8000_0004, 64'h0, 2'd2, 0);
    set_resp(1, d, 0);
    @(negedge clk);
    total++;
    if (dreq.valid !== 1'b1 || stall_m !== 1'b0 || rdata !== want) begin
      bad++; $display("FAIL hold_issue got v=%b s=%b r=%h want 1 0 %h", dreq.valid, stall_m, rdata, want);
    end
    tick();
    for (int h = 0; h < 2; h++) begin
      set_resp(0, {$urandom, $urandom}, h == 1);
      @(negedge clk);
      total++;
      if ({dreq.valid, stall_m, done} !== 3'b001 || rdata !== want) begin
        bad++; $display("FAIL hold_cycle h=%0d got v/s/d=%b r=%h want 001 %h",
                        h, {dreq.valid, stall_m, done}, rdata, want);
      end
      tick();
    end
    set_op(1, 1, 0, 64'h8000_0100, 64'h0, 2'd3, 0);
    set_resp(1, 64'h5555_AAAA_5555_AAAA, 1);
    @(negedge clk);
    total++;
    if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_0100 || rdata !== 64'h5555_AAAA_5555_AAAA) begin
      bad++; $display("FAIL hold_exit got v=%b a=%h r=%h want 1 80000100 5555aaaa5555aaaa",
                      dreq.valid, dreq.addr, rdata);
    end
    tick();
  endtask

  task automatic test_misalign();
    set_op(1, 1, 0, 64'h8000_0002, 64'h0, 2'd2, 0);
    set_resp(0, 64'h0, 1);
    @(negedge clk);
    total++;
    if ({misalign, dreq.valid, stall_m, done} !== 4'b1001) begin
      bad++; $display("FAIL misalign got m/v/s/d=%b want 1001", {misalign, dreq.valid, stall_m, done});
    end
    tick();
  endtask

  task automatic test_reset_busy();
    set_op(1, 1, 0, 64'h8000_2000, 64'h0, 2'd3, 0);
    set_resp(0, 64'h0, 0);
    tick();
    @(negedge clk);
    total++;
    if (dreq.valid !== 1'b1 || stall_m !== 1'b1) begin
      bad++; $display("FAIL rst_busy_pre got v=%b s=%b want 1 1", dreq.valid, stall_m);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (dreq.valid !== 1'b0 || stall_m !== 1'b0) begin
      bad++; $display("FAIL rst_busy_drop got v=%b s=%b want 0 0", dreq.valid, stall_m);
    end
    @(posedge clk); #1;
    set_op(0, 0, 0, 64'h0, 64'h0, 2'd0, 0);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (dreq.valid !== 1'b0 || stall_m !== 1'b0) begin
      bad++; $display("FAIL rst_busy_noretry got v=%b s=%b want 0 0", dreq.valid, stall_m);
    end
    tick();
    set_op(1, 1, 0, 64'h8000_3000, 64'h0, 2'd3, 0);
    set_resp(0, 64'h0, 0);
    @(negedge clk);
    total++;
    if (dreq.valid !== 1'b1 || stall_m !== 1'b1 || dreq.addr !== 64'h8000_3000) begin
      bad++; $display("FAIL rst_busy_next got v=%b s=%b a=%h want 1 1 80003000",
                      dreq.valid, stall_m, dreq.addr);
    end
    tick();
    set_resp(1, 64'hCAFE_F00D_1234_5678, 1);
    @(negedge clk);
    total++;
    if (rdata !== 64'hCAFE_F00D_1234_5678 || stall_m !== 1'b0) begin
      bad++; $display("FAIL rst_busy_done got r=%h s=%b want cafef00d12345678 0", rdata, stall_m);
    end
    tick();
  endtask

  task automatic test_random();
    logic        v, rd, wr, u, acc, adv, ld_mis;
    logic [1:0]  sz;
    logic [63:0] a, wd, bus, want;
    int          lat, nh, kind;
    for (int k = 0; k < 250; k++) begin
      kind = $urandom_range(0, 4);
      v  = (kind != 0) || $urandom_range(0, 1) == 1;
      rd = kind inside {1, 2};
      wr = kind inside {3, 4};
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = {32'h0000_0000, 16'h8000, 16'($urandom)};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      wd = {$urandom, $urandom};
      set_op(v, rd, wr, a, wd, sz, u);
      ld_mis = m_mis(sz, a);
      acc    = v && (rd || wr) && !ld_mis;
      if (!acc) begin
        set_resp(0, {$urandom, $urandom}, 1);
        @(negedge clk);
        total++;
        if ({dreq.valid, stall_m, done, misalign} !== {1'b0, 1'b0, v, v && (rd || wr) && ld_mis}
            || rdata !== 64'h0) begin
          bad++; $display("FAIL rnd_noacc k=%0d got v/s/d/m=%b r=%h want %b 0", k,
                          {dreq.valid, stall_m, done, misalign}, rdata,
                          {1'b0, 1'b0, v, v && (rd || wr) && ld_mis});
        end
        tick();
        continue;
      end
      lat  = $urandom_range(0, 3);
      want = 64'h0;
      adv  = 1'b1;
      for (int c = 0; c <= lat; c++) begin
        bus = {$urandom, $urandom};
        adv = (c == lat) ? 1'($urandom_range(0, 1)) : 1'b0;
        set_resp(c == lat, bus, adv);
        if (c == lat && rd) want = m_load(bus, a, sz, u);
        @(negedge clk);
        total++;
        if (dreq.valid !== 1'b1 || stall_m !== (c < lat) || misalign !== 1'b0
            || rdata !== ((c == lat) ? want : 64'h0)
            || (c < lat && done !== 1'b0) || (c == lat && adv && done !== 1'b1)) begin
          bad++; $display("FAIL rnd_xfer k=%0d c=%0d lat=%0d got v/s/d/m=%b r=%h want s=%b r=%h",
                          k, c, lat, {dreq.valid, stall_m, done, misalign}, rdata,
                          c < lat, (c == lat) ? want : 64'h0);
        end
        total++;
        if (dreq.addr !== a || dreq.size !== m_msize(sz)
            || (wr && (dreq.strobe !== m_strobe(sz, a) || dreq.data !== m_wdata(wd, a)))) begin
          bad++; $display("FAIL rnd_fields k=%0d got a=%h s=%0d st=%h d=%h want a=%h st=%h d=%h",
                          k, dreq.addr, dreq.size, dreq.strobe, dreq.data, a,
                          m_strobe(sz, a), m_wdata(wd, a));
        end
        tick();
      end
      if (!adv) begin
        nh = $urandom_range(1, 3);
        for (int h = 0; h < nh; h++) begin
          set_resp(0, {$urandom, $urandom}, h == nh - 1);
          @(negedge clk);
          total++;
          if ({dreq.valid, stall_m, done} !== 3'b001 || (rd && rdata !== want)) begin
            bad++; $display("FAIL rnd_hold k=%0d h=%0d got v/s/d=%b r=%h want 001 %h",
                            k, h, {dreq.valid, stall_m, done}, rdata, want);
          end
          tick();
        end
      end
    end
  endtask

  initial begin
    set_op(0, 0, 0, 64'h0, 64'h0, 2'd0, 0);
    set_resp(0, 64'h0, 0);
    test_reset();
    test_ld_latency();
    test_lb_ext();
    test_sh();
    test_hold();
    test_misalign();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
